pc_sequencer: RTL and testbench

//  Initiator side of the fetch interface: generates the PC consumed by Fetch each cycle.

---
 rtl/pc_sequencer_pkg.sv | 30 +++
 rtl/next_pc_sel.sv | 57 +++++
 rtl/pc_sequencer.sv | 82 ++++++++
 tb/tb_pc_sequencer.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the PC sequencer and the fetch interface.
//   ADDR_W / DATA_W / CNT_W : PC width, instruction word width, fetch counter width
//   addr_t / block_t / inst_t : PC, instruction word, Fetch output {pc, word}
//   RESET_PC                : PC presented in the first cycle after reset
//   HALT_WORD               : instruction encoding that stops sequencing
//   pcs_state_e             : sequencer state (BOOT -> RUN -> HALTED)
package pc_sequencer_pkg;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 16;
    localparam int CNT_W  = 16;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] block_t;

    typedef struct packed {
        addr_t  pc;
        block_t word;
    } inst_t;

    localparam addr_t  RESET_PC  = 9'd0;
    localparam block_t HALT_WORD = 16'hFFFF;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } pcs_state_e;

endpackage

// File: rtl/next_pc_sel.sv
// Combinational next-PC priority mux.
//   state          : current sequencer state
//   pc             : current PC
//   stall          : hold request
//   do_jump/jump_target, do_branch/branch_target : redirects from Execute
//   halt_seen      : correct-path halt word observed this cycle
//   pc_next        : PC to present next cycle
//   load_en        : a PC is issued this cycle (drives the fetch counter)
module next_pc_sel
    import pc_sequencer_pkg::*;
(
    input  pcs_state_e        state,
    input  logic [ADDR_W-1:0] pc,
    input  logic              stall,
    input  logic              do_jump,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              do_branch,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              halt_seen,
    output logic [ADDR_W-1:0] pc_next,
    output logic              load_en
);

    always_comb begin
        pc_next = pc;
        load_en = 1'b0;
        case (state)
            // Fetch still shows the reset bubble, so redirects and stall are
            // meaningless here; RESET_PC is held for one cycle and counts as issued.
            BOOT: begin
                pc_next = pc;
                load_en = 1'b1;
            end
            RUN: begin
                if (do_jump) begin
                    pc_next = jump_target;
                    load_en = 1'b1;
                end else if (do_branch) begin
                    pc_next = branch_target;
                    load_en = 1'b1;
                end else if (halt_seen || stall) begin
                    pc_next = pc;
                    load_en = 1'b0;
                end else begin
                    // Natural wrap at 2**ADDR_W.
                    pc_next = pc + ADDR_W'(1);
                    load_en = 1'b1;
                end
            end
            default: begin
                pc_next = pc;
                load_en = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// PC sequencer: initiator side of the fetch interface. Presents a PC to Fetch
// every cycle, advancing sequentially, redirecting on jump/branch from Execute,
// holding on stall, and freezing for good once the halt word comes back on the
// correct path.
//   clk, rst (async, active-low)
//   stall, do_branch/branch_target, do_jump/jump_target : control from the pipeline
//   inst        : Fetch output {pc, word}, only the word is examined
//   pc          : address presented to Fetch
//   halted      : sticky halt indication
//   fetch_count : saturating count of PCs issued
module pc_sequencer
    import pc_sequencer_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall,
    input  logic                     do_branch,
    input  logic [ADDR_W-1:0]        branch_target,
    input  logic                     do_jump,
    input  logic [ADDR_W-1:0]        jump_target,
    input  logic [ADDR_W+DATA_W-1:0] inst,
    output logic [ADDR_W-1:0]        pc,
    output logic                     halted,
    output logic [CNT_W-1:0]         fetch_count
);

    pcs_state_e        state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic [CNT_W-1:0]  cnt_reg;
    logic              load_en;
    logic              halt_seen;
    logic              inst_pc_unused;

    // A halt word fetched alongside a redirect is on the squashed path.
    // HALT_WORD is non-zero, so reset/flush bubbles can never match.
    assign halt_seen = (inst[DATA_W-1:0] == HALT_WORD) && !do_branch && !do_jump;

    // The pc half of the Fetch output is not needed to decide on halting.
    assign inst_pc_unused = ^inst[ADDR_W+DATA_W-1:DATA_W];

    next_pc_sel u_next_pc_sel (
        .state         (state_reg),
        .pc            (pc_reg),
        .stall         (stall),
        .do_jump       (do_jump),
        .jump_target   (jump_target),
        .do_branch     (do_branch),
        .branch_target (branch_target),
        .halt_seen     (halt_seen),
        .pc_next       (pc_next),
        .load_en       (load_en)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            BOOT:    state_next = RUN;
            RUN:     state_next = halt_seen ? HALTED : RUN;
            HALTED:  state_next = HALTED;
            default: state_next = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= BOOT;
            pc_reg    <= RESET_PC;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            if (load_en && (cnt_reg != {CNT_W{1'b1}})) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

    assign pc          = pc_reg;
    assign halted      = (state_reg == HALTED);
    assign fetch_count = cnt_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed, table-driven bench for pc_sequencer. Each table row is applied for
// one clock and the registered outputs are compared just after the edge.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        do_branch;
    logic [8:0]  branch_target;
    logic        do_jump;
    logic [8:0]  jump_target;
    logic [24:0] inst;
    logic [8:0]  pc;
    logic        halted;
    logic [15:0] fetch_count;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic        stall;
        logic        do_branch;
        logic [8:0]  branch_target;
        logic        do_jump;
        logic [8:0]  jump_target;
        logic [8:0]  inst_pc;
        logic [15:0] word;
        logic [8:0]  exp_pc;
        logic        exp_halted;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs[$];

    pc_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .do_branch     (do_branch),
        .branch_target (branch_target),
        .do_jump       (do_jump),
        .jump_target   (jump_target),
        .inst          (inst),
        .pc            (pc),
        .halted        (halted),
        .fetch_count   (fetch_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input int e_pc, input int e_h, input int e_cnt);
        chk({tag, " pc"}, int'(pc), e_pc);
        chk({tag, " halted"}, int'(halted), e_h);
        chk({tag, " fetch_count"}, int'(fetch_count), e_cnt);
        $display("[TB] %s: pc=%0d halted=%0d fetch_count=%0d", tag, pc, halted, fetch_count);
    endtask

    task automatic add(input logic s, input logic b, input logic [8:0] bt,
                       input logic j, input logic [8:0] jt,
                       input logic [8:0] ipc, input logic [15:0] w,
                       input logic [8:0] epc, input logic eh, input logic [15:0] ec);
        vec_t v;
        v.stall = s; v.do_branch = b; v.branch_target = bt;
        v.do_jump = j; v.jump_target = jt; v.inst_pc = ipc; v.word = w;
        v.exp_pc = epc; v.exp_halted = eh; v.exp_cnt = ec;
        vecs.push_back(v);
    endtask

    task automatic drive_idle();
        stall = 1'b0; do_branch = 1'b0; branch_target = '0;
        do_jump = 1'b0; jump_target = '0; inst = '0;
    endtask

    initial begin
        //  stall br  btgt  jmp jtgt  ipc  word      pc   h  cnt
        add(0,   0,  0,    0,  0,    0,   16'h0000, 0,   0, 1);   // BOOT -> RUN, pc held
        add(0,   0,  0,    0,  0,    0,   16'h0000, 1,   0, 2);
        add(0,   0,  0,    0,  0,    0,   16'h0000, 2,   0, 3);
        add(0,   0,  0,    0,  0,    0,   16'h0000, 3,   0, 4);
        add(1,   0,  0,    0,  0,    0,   16'h0000, 3,   0, 4);   // stall holds
        add(1,   1,  10,   0,  0,    0,   16'h0000, 10,  0, 5);   // branch beats stall
        add(0,   1,  7,    1,  3,    0,   16'h0000, 3,   0, 6);   // jump beats branch
        add(0,   0,  0,    1,  3,    0,   16'h0000, 3,   0, 7);   // redirect to same pc counts
        add(0,   1,  510,  0,  0,    0,   16'h0000, 510, 0, 8);
        add(0,   0,  0,    0,  0,    0,   16'h0000, 511, 0, 9);
        add(0,   0,  0,    0,  0,    0,   16'h0000, 0,   0, 10);  // wrap 511 -> 0
        add(0,   0,  0,    0,  0,    0,   16'h0000, 1,   0, 11);  // zero word is a NOP
        add(0,   1,  19,   0,  0,    27,  16'hFFFF, 19,  0, 12);  // wrong-path halt (branch)
        add(0,   0,  0,    1,  27,   27,  16'hFFFF, 27,  0, 13);  // wrong-path halt (jump)
        add(0,   0,  0,    0,  0,    0,   16'h0000, 28,  0, 14);
        add(0,   0,  0,    0,  0,    27,  16'hFFFF, 28,  1, 14);  // halt accepted
        add(1,   0,  0,    1,  5,    0,   16'hFFFF, 28,  1, 14);  // HALTED ignores inputs
        add(0,   1,  9,    0,  0,    0,   16'h0000, 28,  1, 14);

        rst = 1'b0;
        drive_idle();
        #1;
        check_out("reset", 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) begin
            stall         = vecs[i].stall;
            do_branch     = vecs[i].do_branch;
            branch_target = vecs[i].branch_target;
            do_jump       = vecs[i].do_jump;
            jump_target   = vecs[i].jump_target;
            inst          = {vecs[i].inst_pc, vecs[i].word};
            @(posedge clk);
            #1;
            check_out($sformatf("row%0d", i), int'(vecs[i].exp_pc),
                      int'(vecs[i].exp_halted), int'(vecs[i].exp_cnt));
            @(negedge clk);
        end

        // Asynchronous reset while HALTED: outputs clear without a clock edge.
        drive_idle();
        #2 rst = 1'b0;
        #1;
        check_out("async_reset", 0, 0, 0);
        @(posedge clk);
        #1;
        check_out("reset_held", 0, 0, 0);

        // BOOT ignores redirect, stall and a halt word.
        @(negedge clk);
        rst = 1'b1;
        stall = 1'b1; do_jump = 1'b1; jump_target = 9'd100;
        inst = {9'd0, 16'hFFFF};
        @(posedge clk);
        #1;
        check_out("boot_ignores", 0, 0, 1);

        // Halt outranks stall; pc stays where the stall held it.
        @(negedge clk);
        do_jump = 1'b0;
        @(posedge clk);
        #1;
        check_out("halt_over_stall", 0, 1, 1);

        @(negedge clk);
        drive_idle();
        @(posedge clk);
        #1;
        check_out("halt_sticky", 0, 1, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
